// File: rtl/dac_slot_serializer_pkg.sv
// Shared definitions for the DAC/ADC slot datapaths of one isolator slot.
package da_slot_pkg;

  localparam int unsigned SAMPLE_BITS  = 24;
  localparam int unsigned NUM_LINES    = 4;
  localparam int unsigned NUM_CHANNELS = 8;

  typedef logic [SAMPLE_BITS-1:0] sample_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

endpackage

// File: rtl/dac_slot_serializer_if.sv
// Sample FIFO handshake: the FIFO is the master, the serializer the slave.
interface dac_slot_serializer_if #(
  parameter int unsigned SAMPLE_BITS = da_slot_pkg::SAMPLE_BITS
);

  logic                   in_ready;
  logic                   in_enable;
  logic [SAMPLE_BITS-1:0] in_data;

  modport master (
    input  in_ready,
    output in_enable,
    output in_data
  );

  modport slave (
    output in_ready,
    input  in_enable,
    input  in_data
  );

endinterface

// File: rtl/dac_slot_serializer_clock_gen.sv
// bck/lrck timing generator: clk divider, bit counter and frame boundary strobe.
module slot_clock_gen #(
  parameter  int unsigned SLOT_BITS = 32,
  parameter  int unsigned BCK_DIV   = 4,
  localparam int unsigned CNT_W     = $clog2(2 * SLOT_BITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  output logic             bck,
  output logic             lrck,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_end
);

  localparam int unsigned      DIV_W    = $clog2(BCK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SLOT_BITS);

  logic [DIV_W-1:0] divider;
  logic             fall_tick;

  // Fall tick is the divider wrap; bit_cnt (and hence lrck/sdata) moves only
  // here, half a bck period away from the bck rising edge.
  assign fall_tick = active && (divider == DIV_LAST);
  assign frame_end = fall_tick && (bit_cnt == CNT_LAST);
  assign bck       = active && (divider >= DIV_HALF);
  assign lrck      = active && (bit_cnt >= CNT_HALF);

  always_ff @(posedge clk) begin
    if (reset || !active) begin
      divider <= '0;
      bit_cnt <= '0;
    end else if (fall_tick) begin
      divider <= '0;
      bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
    end else begin
      divider <= divider + 1'b1;
    end
  end

endmodule

// File: rtl/dac_slot_serializer.sv
// Double-buffered 8-channel PCM serializer driving one DAC slot (bck, lrck, 4 data lines).
module dac_slot_serializer
  import da_slot_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = da_slot_pkg::SAMPLE_BITS,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned BCK_DIV     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  dac_slot_serializer_if.slave  fifo,
  output logic                  bck,
  output logic                  lrck,
  output logic [NUM_LINES-1:0]  sdata,
  output logic                  underrun,
  input  logic                  underrun_clear
);

  localparam int unsigned     CNT_W   = $clog2(2 * SLOT_BITS);
  localparam int unsigned     IDX_W   = $clog2(NUM_CHANNELS);
  localparam int unsigned     LD_W    = $clog2(NUM_CHANNELS + 1);
  localparam int unsigned     BIT_W   = $clog2(SAMPLE_BITS);
  localparam logic [LD_W-1:0] LD_FULL = LD_W'(NUM_CHANNELS);

  typedef logic [SAMPLE_BITS-1:0] word_t;

  state_t           state, state_nxt;
  logic             run_active;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_end;

  logic [LD_W-1:0]  load_cnt;
  logic             load_full;
  logic             xfer;
  word_t            load_buf  [NUM_CHANNELS];
  word_t            shift_buf [NUM_CHANNELS];

  logic [CNT_W-1:0] pos;
  logic [BIT_W-1:0] bit_sel;
  logic [IDX_W-1:0] ch;

  assign run_active = (state == ST_RUN);

  slot_clock_gen #(
    .SLOT_BITS (SLOT_BITS),
    .BCK_DIV   (BCK_DIV)
  ) u_clock_gen (
    .clk       (clk),
    .reset     (reset),
    .active    (run_active),
    .bck       (bck),
    .lrck      (lrck),
    .bit_cnt   (bit_cnt),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (run) state_nxt = ST_RUN;
      ST_RUN:  if (frame_end && !run) state_nxt = ST_IDLE;
    endcase
  end

  assign load_full     = (load_cnt == LD_FULL);
  assign fifo.in_ready = run_active && !load_full;
  assign xfer          = fifo.in_ready && fifo.in_enable;

  // A word landing on the boundary cycle is counted after the boundary has
  // already judged the buffer incomplete, so it waits for the next frame.
  always_ff @(posedge clk) begin
    if (reset)                       load_cnt <= '0;
    else if (frame_end && load_full) load_cnt <= '0;
    else if (xfer)                   load_cnt <= load_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (xfer) load_buf[load_cnt[IDX_W-1:0]] <= fifo.in_data;
  end

  // Cleared while idle so the first frame after starting is always silent.
  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) shift_buf[i] <= '0;
    end else if (frame_end) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++)
        shift_buf[i] <= load_full ? load_buf[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                        underrun <= 1'b0;
    else if (frame_end && !load_full) underrun <= 1'b1;
    else if (underrun_clear)          underrun <= 1'b0;
  end

  // I2S: bit position p=1 carries the MSB, one bck after the lrck edge.
  always_comb begin
    sdata   = '0;
    ch      = '0;
    pos     = lrck ? bit_cnt - CNT_W'(SLOT_BITS) : bit_cnt;
    bit_sel = BIT_W'(SAMPLE_BITS - 32'(pos));
    for (int unsigned k = 0; k < NUM_LINES; k++) begin
      ch = IDX_W'(2 * k) | IDX_W'(lrck);
      if (pos != '0 && pos <= CNT_W'(SAMPLE_BITS))
        sdata[k] = shift_buf[ch][bit_sel];
    end
  end

endmodule

// File: tb/tb_dac_slot_serializer.sv
// Randomized scoreboard bench for dac_slot_serializer with a frame-level reference model.
module tb_dac_slot_serializer;
  import da_slot_pkg::*;

  localparam int SB    = 24;
  localparam int SLOT  = 32;
  localparam int DIV   = 4;
  localparam int FRAME = DIV * 2 * SLOT;

  typedef logic [SB-1:0]   word_t;
  typedef logic [8*SB-1:0] frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       underrun_clear = 1'b0;
  logic       bck, lrck, underrun;
  logic [3:0] sdata;

  dac_slot_serializer_if #(.SAMPLE_BITS(SB)) fifo();

  dac_slot_serializer #(
    .SAMPLE_BITS (SB),
    .SLOT_BITS   (SLOT),
    .BCK_DIV     (DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .fifo           (fifo.slave),
    .bck            (bck),
    .lrck           (lrck),
    .sdata          (sdata),
    .underrun       (underrun),
    .underrun_clear (underrun_clear)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: frame boundaries derived from elapsed cycles since start.
  frame_t exp_q[$];
  frame_t m_buf, m_f;
  frame_t zero_frame = '0;
  bit     m_run = 0, m_under = 0;
  int     m_t = 0, m_cnt = 0;
  bit     m_xfer, m_bnd, m_set;

  initial begin
    forever begin
      @(posedge clk);
      m_set = 0;
      if (reset) begin
        m_run = 0; m_t = 0; m_cnt = 0; m_under = 0;
        exp_q.delete();
      end else begin
        if (!m_run) begin
          if (run) begin
            m_run = 1; m_t = 0;
            exp_q.push_back(zero_frame);
          end
        end else begin
          m_xfer = (m_cnt < 8) && fifo.in_enable;
          m_bnd  = (m_t % FRAME) == FRAME - 1;
          if (m_bnd) begin
            if (m_cnt == 8) begin m_f = m_buf; m_cnt = 0; end
            else begin m_f = '0; m_set = 1; end
            if (run) exp_q.push_back(m_f);
            else     m_run = 0;
          end
          if (m_xfer) begin
            m_buf[m_cnt*SB +: SB] = fifo.in_data;
            m_cnt++;
          end
          m_t++;
        end
        if (m_set) m_under = 1;
        else if (underrun_clear) m_under = 0;
      end
    end
  end

  // Monitor: collects one bit per bck rise and checks each full frame.
  int         r = 0, frames = 0, nz, lr_err;
  logic       prev_bck = 1'b0;
  logic [3:0] mb [64];
  logic       mlr [64];
  word_t      w;
  frame_t     f_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        r = 0; prev_bck = 1'b0;
      end else begin
        chk("in_ready", fifo.in_ready, m_run && (m_cnt < 8));
        chk("underrun", underrun, m_under);
        if (!m_run) chk("idle_pins", {bck, lrck, sdata}, 0);
        if (bck && !prev_bck) begin
          mb[r] = sdata; mlr[r] = lrck; r++;
          if (r == 64) begin
            r = 0;
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL frame_queue: actual=frame emitted required=no frame at %0t", $time);
            end else begin
              f_exp = exp_q.pop_front();
              for (int ch = 0; ch < 8; ch++) begin
                w = '0;
                for (int p = 1; p <= SB; p++) w[SB-p] = mb[(ch % 2) * SLOT + p][ch / 2];
                chk($sformatf("frame%0d_ch%0d", frames, ch), w, f_exp[ch*SB +: SB]);
              end
              nz = 0; lr_err = 0;
              for (int i = 0; i < 64; i++) begin
                if (mlr[i] != (i >= SLOT)) lr_err++;
                if (((i % SLOT) == 0 || (i % SLOT) > SB) && mb[i] != 4'd0) nz++;
              end
              chk($sformatf("frame%0d_pad", frames), nz, 0);
              chk($sformatf("frame%0d_lrck", frames), lr_err, 0);
              frames++;
            end
          end
        end
        prev_bck = bck;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_pins_zero(input string nm);
    chk({nm, "_bck"}, bck, 0);
    chk({nm, "_lrck"}, lrck, 0);
    chk({nm, "_sdata"}, sdata, 0);
    chk({nm, "_in_ready"}, fifo.in_ready, 0);
  endtask

  // Called with run=1 just set (or reset just released with run=1).
  task automatic measure_timing();
    int n;
    tick();
    n = 0;
    while (!bck && n < 20) begin tick(); n++; end
    chk("first_bck_latency", n, DIV / 2);
    n = 0;
    while (bck && n < 20)  begin tick(); n++; end
    while (!bck && n < 20) begin tick(); n++; end
    chk("bck_period", n, DIV);
    n = 0;
    while (!lrck && n < 2 * FRAME) begin tick(); n++; end
    n = 0;
    while (lrck && n < 2 * FRAME)  begin tick(); n++; end
    while (!lrck && n < 2 * FRAME) begin tick(); n++; end
    chk("lrck_period", n, FRAME);
  endtask

  initial begin
    int n, acc;
    fifo.in_enable = 1'b0;
    fifo.in_data   = '0;
    repeat (3) tick();
    check_pins_zero("reset");
    chk("reset_underrun", underrun, 0);
    reset = 1'b0;
    tick();

    // Start with no samples: frame 0 silent and flagged.
    run = 1'b1;
    measure_timing();
    chk("first_frame_underrun", underrun, 1);
    underrun_clear = 1'b1; tick(); underrun_clear = 1'b0;
    chk("underrun_cleared", underrun, 0);

    // Pre-fill 0xA00000+ch for the next frame.
    for (int i = 0; i < 8; i++) begin
      fifo.in_enable = 1'b1;
      fifo.in_data   = word_t'(24'hA00000 + i);
      tick();
    end
    fifo.in_enable = 1'b0;

    // Random-rate stream.
    for (int i = 0; i < 6 * FRAME; i++) begin
      fifo.in_enable = ($urandom_range(0, 3) != 0);
      fifo.in_data   = word_t'($urandom);
      tick();
    end

    // Continuous stream.
    underrun_clear = 1'b1;
    fifo.in_enable = 1'b1;
    fifo.in_data   = word_t'($urandom);
    tick();
    underrun_clear = 1'b0;
    n = 0;
    while ((m_t % FRAME) != 0 && n < 2 * FRAME) begin
      fifo.in_data = word_t'($urandom); tick(); n++;
    end
    for (int f = 0; f < 3; f++) begin
      acc = 0;
      for (int i = 0; i < FRAME; i++) begin
        acc += (fifo.in_ready && fifo.in_enable) ? 1 : 0;
        fifo.in_data = word_t'($urandom);
        tick();
      end
      chk($sformatf("accepts_per_frame%0d", f), acc, 8);
    end
    chk("continuous_no_underrun", underrun, 0);
    fifo.in_enable = 1'b0;

    // 8th word lands on the boundary cycle.
    n = 0;
    while (!((m_t % FRAME) == FRAME - 8 && m_cnt == 0) && n < 3 * FRAME) begin tick(); n++; end
    chk("late8_align_found", n < 3 * FRAME, 1);
    for (int i = 0; i < 8; i++) begin
      fifo.in_enable = 1'b1;
      fifo.in_data   = word_t'(24'hB00000 + i);
      tick();
    end
    fifo.in_enable = 1'b0;
    chk("late8_underrun", underrun, 1);
    chk("late8_ready_low", fifo.in_ready, 0);
    repeat (FRAME + 10) tick();

    // Stop mid-frame: the frame completes, then idle.
    n = 0;
    while ((m_t % FRAME) != 100 && n < 2 * FRAME) begin
      fifo.in_enable = ($urandom_range(0, 1) != 0);
      fifo.in_data   = word_t'($urandom);
      tick(); n++;
    end
    fifo.in_enable = 1'b0;
    run = 1'b0;
    n = 0;
    while (m_run && n < 2 * FRAME) begin tick(); n++; end
    repeat (3) tick();
    check_pins_zero("stopped");
    chk("stop_frames_drained", exp_q.size(), 0);

    // Reset mid-frame.
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      fifo.in_enable = ($urandom_range(0, 1) != 0);
      fifo.in_data   = word_t'($urandom);
      tick();
    end
    fifo.in_enable = 1'b0;
    reset = 1'b1;
    tick();
    check_pins_zero("midframe_reset");
    chk("midframe_reset_underrun", underrun, 0);
    reset = 1'b0;
    measure_timing();
    repeat (FRAME) tick();
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) tick();
    chk("frames_seen_nonzero", frames > 10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
